// File: rtl/serial_comp_ctrl.sv
// ---------------------------------------------------------------------------
// serial_comp_ctrl
//
// Serial unsigned magnitude comparator. The comparator takes two WIDTH-bit
// operands and compares them 2 bits per cycle, starting at the most
// significant slice. It stops at the first slice that differs, or after the
// last slice when the operands are equal.
//
// Ports
//   clk      : single clock; all state updates on its rising edge
//   rst      : synchronous, active-high reset
//   start    : request a comparison (accepted only when idle)
//   a, b     : unsigned operands, latched on the acceptance edge
//   busy     : comparison in progress
//   done     : one-cycle pulse, result flags valid
//   greater  : A > B
//   lesser   : A < B
//   equal    : A == B
//
// All outputs come straight from registers. The result flags hold their
// value until the next start is accepted.
// ---------------------------------------------------------------------------
module serial_comp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             greater,
    output logic             lesser,
    output logic             equal
);

    localparam int SLICES = WIDTH / 2;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic {
        IDLE,
        COMPARE
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               greater_reg, greater_next;
    logic               lesser_reg, lesser_next;
    logic               equal_reg, equal_next;

    // Split the latched operands into 2-bit slices so the active slice can be
    // picked with a plain array index.
    logic [1:0] a_slices [SLICES];
    logic [1:0] b_slices [SLICES];

    genvar gi;
    generate
        for (gi = 0; gi < SLICES; gi++) begin : g_slice
            assign a_slices[gi] = a_reg[2*gi +: 2];
            assign b_slices[gi] = b_reg[2*gi +: 2];
        end
    endgenerate

    logic [1:0] a_slice;
    logic [1:0] b_slice;

    assign a_slice = a_slices[idx_reg];
    assign b_slice = b_slices[idx_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            idx_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            greater_reg <= 1'b0;
            lesser_reg  <= 1'b0;
            equal_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            idx_reg     <= idx_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            greater_reg <= greater_next;
            lesser_reg  <= lesser_next;
            equal_reg   <= equal_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        idx_next     = idx_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;        // done is a single-cycle pulse
        greater_next = greater_reg;
        lesser_next  = lesser_reg;
        equal_next   = equal_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next       = a;
                    b_next       = b;
                    idx_next     = IDX_W'(SLICES - 1);
                    greater_next = 1'b0;
                    lesser_next  = 1'b0;
                    equal_next   = 1'b0;
                    busy_next    = 1'b1;
                    state_next   = COMPARE;
                end
            end

            COMPARE: begin
                if (a_slice != b_slice) begin
                    // The first differing slice from the top decides the result.
                    greater_next = (a_slice > b_slice);
                    lesser_next  = (a_slice < b_slice);
                    done_next    = 1'b1;
                    busy_next    = 1'b0;
                    state_next   = IDLE;
                end else if (idx_reg != '0) begin
                    idx_next = idx_reg - IDX_W'(1);
                end else begin
                    equal_next = 1'b1;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign greater = greater_reg;
    assign lesser  = lesser_reg;
    assign equal   = equal_reg;

endmodule

// File: doc/serial_comp_ctrl.md
SERIAL_COMP_CTRL -- requirements
Module: serial_comp_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits; WIDTH SHALL be even and >= 2.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a comparison.
REQ-005 The module SHALL have port a, input, WIDTH bits: operand A, unsigned.
REQ-006 The module SHALL have port b, input, WIDTH bits: operand B, unsigned.
REQ-007 The module SHALL have port busy, output, 1 bit: a comparison is in progress.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 The module SHALL have ports greater, lesser and equal, each an output of 1 bit, giving the result flags A>B, A<B and A==B.

Function
REQ-010 The controller SHALL compare A and B serially, 2 bits per cycle, starting with the most significant slice, using a 2-bit magnitude-compare step.
REQ-011 The FSM SHALL have two states: IDLE and COMPARE.
REQ-012 In IDLE, when start=1 at a rising edge, the controller SHALL:
- latch a and b into internal operand registers;
- set the slice index to WIDTH/2-1 (the MS slice);
- clear greater, lesser and equal to 0;
- set busy=1;
- enter COMPARE.
REQ-013 Each COMPARE cycle SHALL compare latched A[2i+1:2i] against latched B[2i+1:2i], where i is the current slice index.
REQ-014 If the slices are unequal, at the next edge the controller SHALL:
- set greater=1 if the A slice is larger, otherwise set lesser=1;
- assert done=1 and set busy=0;
- return to IDLE.
REQ-015 If the slices are equal and i>0, the controller SHALL decrement i by 1 and remain in COMPARE.
REQ-016 If the slices are equal and i=0, at the next edge the controller SHALL set equal=1, assert done=1, set busy=0 and return to IDLE.
REQ-017 Latency: if start is accepted at edge E0, done SHALL be high in the cycle following edge Ek.
- k = 1-based position, counted from the MSB, of the first unequal slice;
- k = WIDTH/2 if no slice is unequal;
- the range of k is 1..WIDTH/2.
REQ-018 done SHALL be high for exactly one cycle per accepted start.
REQ-019 When done=1, exactly one of greater, lesser and equal SHALL be 1.
REQ-020 The result flags SHALL hold their value after done until the next start is accepted.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 Changes on a and b after the acceptance edge SHALL NOT affect the result.
REQ-023 A start present during the cycle in which done=1 SHALL be accepted, because the FSM is in IDLE; the flags SHALL clear at that edge.
REQ-024 busy SHALL be 1 from the acceptance edge through the deciding edge, and 0 otherwise.
REQ-025 No combinational path SHALL exist from start, a or b to any output; all outputs SHALL be registered.

Reset
REQ-026 When rst=1 at a rising edge, the controller SHALL:
- enter IDLE;
- force busy, done, greater, lesser and equal to 0;
- clear the slice index and the operand registers.
REQ-027 rst SHALL take priority over start and over any in-progress comparison; an aborted comparison SHALL produce no done pulse.
REQ-028 The first start with rst=0 after reset SHALL be accepted normally.

Verification (WIDTH=8)
REQ-029 Early decision: start with a=8'hA5, b=8'h25 -> done 1 cycle after acceptance; greater=1, lesser=0, equal=0; busy high for 1 cycle.
REQ-030 Full-length equal: a=8'h3C, b=8'h3C -> done 4 cycles after acceptance; equal=1, greater=0, lesser=0.
REQ-031 Last-slice decision: a=8'h12, b=8'h13 -> done 4 cycles after acceptance; lesser=1, greater=0, equal=0.
REQ-032 Ignored inputs while busy: start a=8'h40, b=8'h41; one cycle later drive start=1 with a=8'hFF, b=8'h00 -> single done after 4 cycles with lesser=1; no second done.
REQ-033 Reset mid-operation: start a=8'h01, b=8'h01; assert rst 2 cycles later -> next cycle all outputs 0 and no done; a following start with a=8'h80, b=8'h00 -> done after 1 cycle with greater=1.
REQ-034 Back-to-back: start a=8'hC0, b=8'h40 (done after 1 cycle, greater=1); start held high in the done cycle with a=8'h00, b=8'h00 -> flags clear at that edge; done again 4 cycles later with equal=1.
